ram_banked_sync: RTL and testbench
==================================

// Module: ram_banked_sync
// PURPOSE
//  Parametrised byte-banked RAM with one data port (A, read/write) and one fetch port (B, read-only).
//  - Reads are registered (1-cycle latency) so the arrays map onto true-dual-port block RAM.
//  - Adds valid/ready handshakes, LB/LH sign extension, a misalignment policy, range checking
//    and a post-reset clear sequencer.
//  - Sits between the rv32i core's LSU/fetch stages and on-chip memory.
// PARAMETERS
//  ADDR_LENGTH       21  byte-address bits decoded; capacity = 2**ADDR_LENGTH bytes
//  NUM_BANKS         4   byte lanes (power of 2, >=2); data width = 8*NUM_BANKS
//  MISALIGNED_MODE   0   0 = misaligned access done in one beat; 1 = rejected with a_err
//  CLEAR_ON_RESET    1   1 = zero all banks after reset before accepting requests
// PORTS
//  clk        in   1            rising-edge clock
//  reset_n    in   1            synchronous active-low reset
//  a_req      in   1            port A request valid
//  a_ready    out  1            port A can accept (high in RUN state only)
//  a_we       in   1            1 = store, 0 = load
//  a_addr     in   32           byte address
//  a_size     in   2            0 = byte, 1 = half, 2 = word; 3 is treated as word
//  a_signed   in   1            sign-extend load result (byte/half only)
//  a_wdata    in   8*NUM_BANKS  store data, LSB-aligned
//  a_rvalid   out  1            a_rdata/a_err valid this cycle
//  a_rdata    out  8*NUM_BANKS  load data, LSB-aligned, zero/sign extended
//  a_err      out  1            access fault, qualified by a_rvalid
//  b_req      in   1            port B read request
//  b_ready    out  1            port B can accept (same as a_ready)
//  b_addr     in   32           byte address, full word always returned
//  b_rvalid   out  1            b_rdata valid
//  b_rdata    out  8*NUM_BANKS  fetch data
// BEHAVIOUR
//  - Reset: a_rvalid = b_rvalid = a_err = 0; a_rdata = b_rdata = 0.
//    The state goes to CLEAR if CLEAR_ON_RESET, otherwise to RUN.
//    Reset asserted mid-CLEAR restarts the clear from index 0. Memory contents are not reset otherwise.
//  - FSM CLEAR:
//    - Counter idx runs 0 .. 2**ADDR_LENGTH/NUM_BANKS-1 and writes 0 to every bank at idx, one per cycle.
//    - a_ready = b_ready = 0 throughout; requests are ignored.
//    - At the last idx the FSM moves to RUN on the next cycle.
//  - FSM RUN: a_ready = b_ready = 1. There is no way back to CLEAR except reset.
//  - Handshake: a request is accepted when req & ready at a rising edge.
//    - rvalid pulses exactly 1 cycle later, once per accepted request (stores included on port A).
//    - Back-to-back accepts every cycle are allowed; there is no backpressure on responses.
//  - Banking: lane L = (addr + k) mod NUM_BANKS for byte k.
//    - Bank row = addr[ADDR_LENGTH-1:log2 NUM_BANKS], +1 for lanes below addr's offset.
//    - The top row wraps to row 0, with no error.
//  - Range check: a_err = 1 and no write occurs when addr[31:ADDR_LENGTH] != 0.
//    - An out-of-range port B access returns b_rdata = 0; port B has no error signal.
//  - Misaligned (addr mod size-bytes != 0):
//    - Mode 0: access completes normally across rows.
//    - Mode 1: a_err = 1, no write, a_rdata = 0.
//  - Loads: byte/half results are zero-extended, or sign-extended from bit 7/15 when a_signed.
//    When a_err = 1, a_rdata = 0.
//  - Stores write only the size-bytes lanes. Store responses return a_rdata = 0.
//  - Same-cycle port A store and port B read of an overlapping byte: port B returns the old data.
//    The store is visible to any request accepted one or more cycles later.
//  - A load accepted the cycle after a store to the same bytes returns the new data.
// TESTING
//  1. Clear sequence:
//     - CLEAR_ON_RESET=1, ADDR_LENGTH=6 -> ready low for exactly 16 cycles after reset_n rises.
//     - After that, a read at 0x3C returns 0.
//  2. Aligned:
//     - SW 0x11223344 @0x100, then LW @0x100 -> a_rdata=0x11223344, a_rvalid one cycle after accept.
//     - LBU @0x101 -> 0x33; LB @0x103 (data 0x80..) -> 0xFFFFFF80.
//  3. Misaligned, mode 0:
//     - SW 0xAABBCCDD @0x103, then LW @0x103 -> 0xAABBCCDD.
//     - LW @0x100 -> low byte 0xDD in bits 31:24.
//     - Mode 1: same SW -> a_err=1, memory unchanged.
//  4. Out of range:
//     - LW @0x0020_0000 with ADDR_LENGTH=21 -> a_err=1, a_rdata=0.
//     - SW to the same address does not alias row 0.
//  5. Collision:
//     - SW 0x5 @0x40 while b_addr=0x40 in the same cycle -> b_rdata = old value.
//     - Next-cycle b read of 0x40 -> 0x5.
//  6. Reset mid-operation:
//     - Drop reset_n during CLEAR and with a load in flight -> rvalid=0 the next cycle.
//     - The clear restarts and takes the full length again.

Source files
------------

// File: rtl/ram_banked_sync_if.sv
// Request/response bundle for ram_banked_sync.
// Port A carries loads and stores. Port B carries read-only instruction fetches.
interface ram_banked_sync_if #(
   parameter int NUM_BANKS = 4
);
   localparam int DW = 8 * NUM_BANKS;

   logic          a_req;
   logic          a_ready;
   logic          a_we;
   logic [31:0]   a_addr;
   logic [1:0]    a_size;
   logic          a_signed;
   logic [DW-1:0] a_wdata;
   logic          a_rvalid;
   logic [DW-1:0] a_rdata;
   logic          a_err;

   logic          b_req;
   logic          b_ready;
   logic [31:0]   b_addr;
   logic          b_rvalid;
   logic [DW-1:0] b_rdata;

   modport slave (
      input  a_req, a_we, a_addr, a_size, a_signed, a_wdata, b_req, b_addr,
      output a_ready, a_rvalid, a_rdata, a_err, b_ready, b_rvalid, b_rdata
   );

   modport master (
      output a_req, a_we, a_addr, a_size, a_signed, a_wdata, b_req, b_addr,
      input  a_ready, a_rvalid, a_rdata, a_err, b_ready, b_rvalid, b_rdata
   );
endinterface

// File: rtl/ram_banked_sync.sv
// Byte-banked RAM with a load/store port (A) and a fetch port (B).
// Each bank is a true-dual-port array with registered reads, and all accesses have one cycle of latency.
module ram_banked_sync #(
   parameter int ADDR_LENGTH     = 21,
   parameter int NUM_BANKS       = 4,
   parameter int MISALIGNED_MODE = 0,
   parameter int CLEAR_ON_RESET  = 1
) (
   input logic              clk,
   input logic              reset_n,
   ram_banked_sync_if.slave bus
);
   localparam int DW   = 8 * NUM_BANKS;
   localparam int DWW  = $clog2(DW);
   localparam int OFFW = $clog2(NUM_BANKS);
   localparam int ROWW = ADDR_LENGTH - OFFW;
   localparam int ROWS = 2 ** ROWW;

   typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

   state_t          state_q, state_d;
   logic [ROWW-1:0] idx_q, idx_d;
   logic            ready;
   logic            a_accept, b_accept;

   logic [OFFW-1:0] a_off, a_k;
   logic [ROWW-1:0] a_row;
   logic [OFFW:0]   a_nbytes;
   logic            a_range_err, a_misaligned, a_fault;
   logic [ROWW-1:0] a_lane_row [NUM_BANKS];
   logic [7:0]      a_lane_wdata [NUM_BANKS];
   logic [NUM_BANKS-1:0] a_lane_we;

   logic [OFFW-1:0] b_off;
   logic [ROWW-1:0] b_row;
   logic            b_range_err;
   logic [ROWW-1:0] b_lane_row [NUM_BANKS];

   logic [7:0]      a_bank_q [NUM_BANKS];
   logic [7:0]      b_bank_q [NUM_BANKS];

   logic            a_rvalid_q, a_rvalid_d;
   logic            a_err_q, a_err_d;
   logic            a_load_q, a_load_d;
   logic [OFFW-1:0] a_off_q, a_off_d;
   logic [1:0]      a_size_q, a_size_d;
   logic            a_signed_q, a_signed_d;
   logic            b_rvalid_q, b_rvalid_d;
   logic            b_err_q, b_err_d;
   logic [OFFW-1:0] b_off_q, b_off_d;

   logic [DW-1:0]   a_raw, a_ext, b_raw;
   int              a_bits;
   logic            a_fill;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      if (state_q == ST_CLEAR) begin
         idx_d = idx_q + 1'b1;
         if (&idx_q) begin
            state_d = ST_RUN;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   assign ready       = (state_q == ST_RUN);
   assign bus.a_ready = ready;
   assign bus.b_ready = ready;
   assign a_accept    = bus.a_req & ready & reset_n;
   assign b_accept    = bus.b_req & ready & reset_n;

   // Port A decode. Byte k of the access goes to lane (off + k).
   // Lanes below the offset fall into the next row, and that row index wraps at the top.
   always_comb begin
      a_off       = bus.a_addr[OFFW-1:0];
      a_row       = bus.a_addr[ADDR_LENGTH-1:OFFW];
      a_range_err = (bus.a_addr >> ADDR_LENGTH) != 32'd0;
      case (bus.a_size)
         2'd0:    a_nbytes = (OFFW+1)'(1);
         2'd1:    a_nbytes = (OFFW+1)'(2);
         default: a_nbytes = (OFFW+1)'(NUM_BANKS);
      endcase
      a_misaligned = (a_off & (a_nbytes[OFFW-1:0] - 1'b1)) != '0;
      a_fault      = a_range_err | ((MISALIGNED_MODE != 0) & a_misaligned);
      a_k          = '0;
      for (int l = 0; l < NUM_BANKS; l++) begin
         a_k             = OFFW'(l) - a_off;
         a_lane_row[l]   = (OFFW'(l) < a_off) ? a_row + 1'b1 : a_row;
         a_lane_wdata[l] = bus.a_wdata[8*a_k +: 8];
         a_lane_we[l]    = a_accept & bus.a_we & ~a_fault & ({1'b0, a_k} < a_nbytes);
      end
   end

   always_comb begin
      b_off       = bus.b_addr[OFFW-1:0];
      b_row       = bus.b_addr[ADDR_LENGTH-1:OFFW];
      b_range_err = (bus.b_addr >> ADDR_LENGTH) != 32'd0;
      for (int l = 0; l < NUM_BANKS; l++) begin
         b_lane_row[l] = (OFFW'(l) < b_off) ? b_row + 1'b1 : b_row;
      end
   end

   // Port A shares its row address between the read and the write, so each bank stays read-first dual-port.
   for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
      logic [7:0]      mem [ROWS];
      logic            wr_en;
      logic [ROWW-1:0] wr_row;
      logic [7:0]      wr_data;

      always_comb begin
         wr_en   = a_lane_we[g];
         wr_row  = a_lane_row[g];
         wr_data = a_lane_wdata[g];
         if (state_q == ST_CLEAR) begin
            wr_en   = 1'b1;
            wr_row  = idx_q;
            wr_data = '0;
         end
      end

      always_ff @(posedge clk) begin
         if (wr_en) begin
            mem[wr_row] <= wr_data;
         end
         if (a_accept) begin
            a_bank_q[g] <= mem[wr_row];
         end
      end

      always_ff @(posedge clk) begin
         if (b_accept) begin
            b_bank_q[g] <= mem[b_lane_row[g]];
         end
      end
   end

   always_comb begin
      a_rvalid_d = a_accept;
      a_err_d    = a_accept & a_fault;
      a_load_d   = a_accept ? ~bus.a_we : a_load_q;
      a_off_d    = a_accept ? a_off : a_off_q;
      a_size_d   = a_accept ? bus.a_size : a_size_q;
      a_signed_d = a_accept ? bus.a_signed : a_signed_q;
      b_rvalid_d = b_accept;
      b_err_d    = b_accept ? b_range_err : b_err_q;
      b_off_d    = b_accept ? b_off : b_off_q;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         a_rvalid_q <= 1'b0;
         a_err_q    <= 1'b0;
         a_load_q   <= 1'b0;
         a_off_q    <= '0;
         a_size_q   <= '0;
         a_signed_q <= 1'b0;
         b_rvalid_q <= 1'b0;
         b_err_q    <= 1'b0;
         b_off_q    <= '0;
      end else begin
         a_rvalid_q <= a_rvalid_d;
         a_err_q    <= a_err_d;
         a_load_q   <= a_load_d;
         a_off_q    <= a_off_d;
         a_size_q   <= a_size_d;
         a_signed_q <= a_signed_d;
         b_rvalid_q <= b_rvalid_d;
         b_err_q    <= b_err_d;
         b_off_q    <= b_off_d;
      end
   end

   // Rotate bank outputs back to LSB-aligned order, then zero- or sign-extend from the access size.
   always_comb begin
      a_raw = '0;
      b_raw = '0;
      for (int k = 0; k < NUM_BANKS; k++) begin
         a_raw[8*k +: 8] = a_bank_q[OFFW'(k) + a_off_q];
         b_raw[8*k +: 8] = b_bank_q[OFFW'(k) + b_off_q];
      end
      case (a_size_q)
         2'd0:    a_bits = 8;
         2'd1:    a_bits = 16;
         default: a_bits = DW;
      endcase
      a_fill = a_signed_q & a_raw[DWW'(a_bits - 1)];
      a_ext  = '0;
      for (int i = 0; i < DW; i++) begin
         a_ext[i] = (i < a_bits) ? a_raw[i] : a_fill;
      end
   end

   assign bus.a_rvalid = a_rvalid_q;
   assign bus.a_err    = a_err_q;
   assign bus.a_rdata  = (a_rvalid_q & a_load_q & ~a_err_q) ? a_ext : '0;
   assign bus.b_rvalid = b_rvalid_q;
   assign bus.b_rdata  = (b_rvalid_q & ~b_err_q) ? b_raw : '0;
endmodule

// File: tb/tb_ram_banked_sync.sv
// Directed self-checking bench for ram_banked_sync.
// Instances: main (21-bit, no clear), strict misalignment (mode 1), and a 6-bit clearing RAM.
module tb_ram_banked_sync;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_main_n, rst_m1_n, rst_clr_n;
   int   checks   = 0;
   int   failures = 0;

   ram_banked_sync_if #(.NUM_BANKS(4)) if_main ();
   ram_banked_sync_if #(.NUM_BANKS(4)) if_m1 ();
   ram_banked_sync_if #(.NUM_BANKS(4)) if_clr ();

   ram_banked_sync #(.ADDR_LENGTH(21), .NUM_BANKS(4), .MISALIGNED_MODE(0), .CLEAR_ON_RESET(0))
      u_main (.clk(clk), .reset_n(rst_main_n), .bus(if_main.slave));
   ram_banked_sync #(.ADDR_LENGTH(10), .NUM_BANKS(4), .MISALIGNED_MODE(1), .CLEAR_ON_RESET(0))
      u_m1 (.clk(clk), .reset_n(rst_m1_n), .bus(if_m1.slave));
   ram_banked_sync #(.ADDR_LENGTH(6), .NUM_BANKS(4), .MISALIGNED_MODE(0), .CLEAR_ON_RESET(1))
      u_clr (.clk(clk), .reset_n(rst_clr_n), .bus(if_clr.slave));

   task automatic set_a(input int dut, input logic req, input logic we, input logic [31:0] addr,
                        input logic [1:0] size, input logic sgn, input logic [31:0] wdata);
      case (dut)
         0: begin
            if_main.a_req = req; if_main.a_we = we; if_main.a_addr = addr;
            if_main.a_size = size; if_main.a_signed = sgn; if_main.a_wdata = wdata;
         end
         1: begin
            if_m1.a_req = req; if_m1.a_we = we; if_m1.a_addr = addr;
            if_m1.a_size = size; if_m1.a_signed = sgn; if_m1.a_wdata = wdata;
         end
         default: begin
            if_clr.a_req = req; if_clr.a_we = we; if_clr.a_addr = addr;
            if_clr.a_size = size; if_clr.a_signed = sgn; if_clr.a_wdata = wdata;
         end
      endcase
   endtask

   task automatic get_a(input int dut, output logic [31:0] rdata, output logic err, output logic rv);
      case (dut)
         0:       begin rdata = if_main.a_rdata; err = if_main.a_err; rv = if_main.a_rvalid; end
         1:       begin rdata = if_m1.a_rdata;   err = if_m1.a_err;   rv = if_m1.a_rvalid;   end
         default: begin rdata = if_clr.a_rdata;  err = if_clr.a_err;  rv = if_clr.a_rvalid;  end
      endcase
   endtask

   // Presents one port A request for one edge, then samples the response just after that edge.
   task automatic a_access(input int dut, input logic we, input logic [31:0] addr, input logic [1:0] size,
                           input logic sgn, input logic [31:0] wdata,
                           output logic [31:0] rdata, output logic err, output logic rv);
      set_a(dut, 1'b1, we, addr, size, sgn, wdata);
      @(posedge clk); #1;
      set_a(dut, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
      get_a(dut, rdata, err, rv);
   endtask

   task automatic b_access(input logic [31:0] addr, output logic [31:0] rdata, output logic rv);
      if_main.b_req = 1'b1; if_main.b_addr = addr;
      @(posedge clk); #1;
      if_main.b_req = 1'b0;
      rdata = if_main.b_rdata; rv = if_main.b_rvalid;
   endtask

   task automatic test_reset();
      for (int d = 0; d < 3; d++) set_a(d, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
      if_main.b_req = 1'b0; if_main.b_addr = '0;
      if_m1.b_req = 1'b0;   if_m1.b_addr = '0;
      if_clr.b_req = 1'b0;  if_clr.b_addr = '0;
      rst_main_n = 1'b0; rst_m1_n = 1'b0; rst_clr_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (if_main.a_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL reset_a_rvalid got %b want 0", if_main.a_rvalid); end
      checks++; if (if_main.b_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL reset_b_rvalid got %b want 0", if_main.b_rvalid); end
      checks++; if (if_main.a_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_a_err got %b want 0", if_main.a_err); end
      checks++; if (if_main.a_rdata !== 32'h0) begin failures++; $display("[TB] FAIL reset_a_rdata got %h want 0", if_main.a_rdata); end
      checks++; if (if_main.b_rdata !== 32'h0) begin failures++; $display("[TB] FAIL reset_b_rdata got %h want 0", if_main.b_rdata); end
      checks++; if (if_clr.a_ready !== 1'b0 || if_clr.b_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_clr_ready got %b%b want 00", if_clr.a_ready, if_clr.b_ready); end
      rst_main_n = 1'b1; rst_m1_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (if_main.a_ready !== 1'b1 || if_main.b_ready !== 1'b1) begin failures++; $display("[TB] FAIL run_ready got %b%b want 11", if_main.a_ready, if_main.b_ready); end
   endtask

   task automatic test_clear();
      int n;
      logic saw_rv;
      logic [31:0] rd; logic er, rv;
      n = 0; saw_rv = 1'b0;
      rst_clr_n = 1'b1;
      set_a(2, 1'b1, 1'b0, 32'h3C, 2'd2, 1'b0, 32'h0);
      while (n < 40) begin
         @(posedge clk); #1;
         n++;
         if (if_clr.a_rvalid) saw_rv = 1'b1;
         if (if_clr.a_ready) break;
      end
      set_a(2, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
      checks++; if (n !== 16) begin failures++; $display("[TB] FAIL clear_length got %0d cycles want 16", n); end
      checks++; if (saw_rv !== 1'b0) begin failures++; $display("[TB] FAIL clear_ignores_req got rvalid=%b want 0", saw_rv); end
      a_access(2, 1'b0, 32'h3C, 2'd2, 1'b0, 32'h0, rd, er, rv);
      checks++; if (rv !== 1'b1 || er !== 1'b0 || rd !== 32'h0) begin failures++; $display("[TB] FAIL clear_read_3c got rv=%b err=%b data=%h want 1 0 00000000", rv, er, rd); end
   endtask

   task automatic test_aligned();
      logic [31:0] rd; logic er, rv;
      a_access(0, 1'b1, 32'h100, 2'd2, 1'b0, 32'h11223344, rd, er, rv);
      checks++; if (rv !== 1'b1 || er !== 1'b0 || rd !== 32'h0) begin failures++; $display("[TB] FAIL sw_resp got rv=%b err=%b data=%h want 1 0 00000000", rv, er, rd); end
      a_access(0, 1'b0, 32'h100, 2'd2, 1'b0, 32'h0, rd, er, rv);
      checks++; if (rv !== 1'b1 || rd !== 32'h11223344) begin failures++; $display("[TB] FAIL lw_100 got rv=%b data=%h want 1 11223344", rv, rd); end
      @(posedge clk); #1;
      checks++; if (if_main.a_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL rvalid_pulse got %b want 0", if_main.a_rvalid); end
      a_access(0, 1'b0, 32'h101, 2'd0, 1'b0, 32'h0, rd, er, rv);
      checks++; if (rd !== 32'h33) begin failures++; $display("[TB] FAIL lbu_101 got %h want 00000033", rd); end
      a_access(0, 1'b1, 32'h103, 2'd0, 1'b0, 32'h80, rd, er, rv);
      a_access(0, 1'b0, 32'h103, 2'd0, 1'b1, 32'h0, rd, er, rv);
      checks++; if (rd !== 32'hFFFFFF80) begin failures++; $display("[TB] FAIL lb_103 got %h want ffffff80", rd); end
      a_access(0, 1'b0, 32'h103, 2'd0, 1'b0, 32'h0, rd, er, rv);
      checks++; if (rd !== 32'h80) begin failures++; $display("[TB] FAIL lbu_103 got %h want 00000080", rd); end
      a_access(0, 1'b0, 32'h102, 2'd1, 1'b1, 32'h0, rd, er, rv);
      checks++; if (rd !== 32'hFFFF8022) begin failures++; $display("[TB] FAIL lh_102 got %h want ffff8022", rd); end
      a_access(0, 1'b0, 32'h100, 2'd2, 1'b0, 32'h0, rd, er, rv);
      checks++; if (rd !== 32'h80223344) begin failures++; $display("[TB] FAIL sb_lane_only got %h want 80223344", rd); end
   endtask

   task automatic test_misaligned();
      logic [31:0] rd; logic er, rv;
      a_access(0, 1'b1, 32'h103, 2'd2, 1'b0, 32'hAABBCCDD, rd, er, rv);
      checks++; if (er !== 1'b0) begin failures++; $display("[TB] FAIL mis_sw_err got %b want 0", er); end
      a_access(0, 1'b0, 32'h103, 2'd2, 1'b0, 32'h0, rd, er, rv);
      checks++; if (rd !== 32'hAABBCCDD) begin failures++; $display("[TB] FAIL mis_lw_103 got %h want aabbccdd", rd); end
      a_access(0, 1'b0, 32'h100, 2'd2, 1'b0, 32'h0, rd, er, rv);
      checks++; if (rd !== 32'hDD223344) begin failures++; $display("[TB] FAIL mis_lw_100 got %h want dd223344", rd); end
      a_access(0, 1'b0, 32'h105, 2'd1, 1'b0, 32'h0, rd, er, rv);
      checks++; if (rd !== 32'hAABB) begin failures++; $display("[TB] FAIL mis_lhu_105 got %h want 0000aabb", rd); end
      a_access(0, 1'b0, 32'h103, 2'd1, 1'b1, 32'h0, rd, er, rv);
      checks++; if (rd !== 32'hFFFFCCDD) begin failures++; $display("[TB] FAIL mis_lh_103 got %h want ffffccdd", rd); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd; logic er, rv;
      set_a(0, 1'b1, 1'b0, 32'h100, 2'd2, 1'b0, 32'h0);
      @(posedge clk); #1;
      get_a(0, rd, er, rv);
      set_a(0, 1'b1, 1'b0, 32'h103, 2'd2, 1'b0, 32'h0);
      checks++; if (rv !== 1'b1 || rd !== 32'hDD223344) begin failures++; $display("[TB] FAIL b2b_0 got rv=%b data=%h want 1 dd223344", rv, rd); end
      @(posedge clk); #1;
      get_a(0, rd, er, rv);
      set_a(0, 1'b1, 1'b0, 32'h106, 2'd0, 1'b0, 32'h0);
      checks++; if (rv !== 1'b1 || rd !== 32'hAABBCCDD) begin failures++; $display("[TB] FAIL b2b_1 got rv=%b data=%h want 1 aabbccdd", rv, rd); end
      @(posedge clk); #1;
      get_a(0, rd, er, rv);
      set_a(0, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
      checks++; if (rv !== 1'b1 || rd !== 32'hAA) begin failures++; $display("[TB] FAIL b2b_2 got rv=%b data=%h want 1 000000aa", rv, rd); end
      @(posedge clk); #1;
      checks++; if (if_main.a_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_idle got %b want 0", if_main.a_rvalid); end
   endtask

   task automatic test_range();
      logic [31:0] rd; logic er, rv;
      a_access(0, 1'b1, 32'h0, 2'd2, 1'b0, 32'h01020304, rd, er, rv);
      a_access(0, 1'b0, 32'h0020_0000, 2'd2, 1'b0, 32'h0, rd, er, rv);
      checks++; if (rv !== 1'b1 || er !== 1'b1 || rd !== 32'h0) begin failures++; $display("[TB] FAIL oor_lw got rv=%b err=%b data=%h want 1 1 00000000", rv, er, rd); end
      a_access(0, 1'b1, 32'h0020_0000, 2'd2, 1'b0, 32'hDEADBEEF, rd, er, rv);
      checks++; if (er !== 1'b1) begin failures++; $display("[TB] FAIL oor_sw_err got %b want 1", er); end
      a_access(0, 1'b0, 32'h0, 2'd2, 1'b0, 32'h0, rd, er, rv);
      checks++; if (rd !== 32'h01020304) begin failures++; $display("[TB] FAIL oor_no_alias got %h want 01020304", rd); end
      b_access(32'h0020_0000, rd, rv);
      checks++; if (rv !== 1'b1 || rd !== 32'h0) begin failures++; $display("[TB] FAIL oor_b got rv=%b data=%h want 1 00000000", rv, rd); end
      b_access(32'h0, rd, rv);
      checks++; if (rd !== 32'h01020304) begin failures++; $display("[TB] FAIL b_read_0 got %h want 01020304", rd); end
   endtask

   task automatic test_wrap();
      logic [31:0] rd; logic er, rv;
      a_access(0, 1'b1, 32'h1FFFFE, 2'd2, 1'b0, 32'h12345678, rd, er, rv);
      checks++; if (er !== 1'b0) begin failures++; $display("[TB] FAIL wrap_sw_err got %b want 0", er); end
      a_access(0, 1'b0, 32'h0, 2'd1, 1'b0, 32'h0, rd, er, rv);
      checks++; if (rd !== 32'h1234) begin failures++; $display("[TB] FAIL wrap_lhu_0 got %h want 00001234", rd); end
      a_access(0, 1'b0, 32'h1FFFFE, 2'd1, 1'b0, 32'h0, rd, er, rv);
      checks++; if (rd !== 32'h5678) begin failures++; $display("[TB] FAIL wrap_lhu_top got %h want 00005678", rd); end
      a_access(0, 1'b0, 32'h2, 2'd1, 1'b0, 32'h0, rd, er, rv);
      checks++; if (rd !== 32'h0102) begin failures++; $display("[TB] FAIL wrap_untouched got %h want 00000102", rd); end
   endtask

   task automatic test_mode1();
      logic [31:0] rd; logic er, rv;
      a_access(1, 1'b1, 32'h104, 2'd2, 1'b0, 32'h05060708, rd, er, rv);
      checks++; if (er !== 1'b0) begin failures++; $display("[TB] FAIL m1_aligned_sw got err=%b want 0", er); end
      a_access(1, 1'b1, 32'h103, 2'd2, 1'b0, 32'hAABBCCDD, rd, er, rv);
      checks++; if (rv !== 1'b1 || er !== 1'b1 || rd !== 32'h0) begin failures++; $display("[TB] FAIL m1_mis_sw got rv=%b err=%b data=%h want 1 1 00000000", rv, er, rd); end
      a_access(1, 1'b0, 32'h104, 2'd2, 1'b0, 32'h0, rd, er, rv);
      checks++; if (rd !== 32'h05060708) begin failures++; $display("[TB] FAIL m1_unchanged got %h want 05060708", rd); end
      a_access(1, 1'b0, 32'h102, 2'd2, 1'b0, 32'h0, rd, er, rv);
      checks++; if (er !== 1'b1 || rd !== 32'h0) begin failures++; $display("[TB] FAIL m1_mis_lw got err=%b data=%h want 1 00000000", er, rd); end
      a_access(1, 1'b0, 32'h106, 2'd1, 1'b0, 32'h0, rd, er, rv);
      checks++; if (er !== 1'b0 || rd !== 32'h0506) begin failures++; $display("[TB] FAIL m1_lhu_106 got err=%b data=%h want 0 00000506", er, rd); end
      a_access(1, 1'b0, 32'h105, 2'd1, 1'b0, 32'h0, rd, er, rv);
      checks++; if (er !== 1'b1) begin failures++; $display("[TB] FAIL m1_mis_lh got err=%b want 1", er); end
   endtask

   task automatic test_collision();
      logic [31:0] rd; logic er, rv;
      a_access(0, 1'b1, 32'h40, 2'd2, 1'b0, 32'h77, rd, er, rv);
      set_a(0, 1'b1, 1'b1, 32'h40, 2'd2, 1'b0, 32'h5);
      if_main.b_req = 1'b1; if_main.b_addr = 32'h40;
      @(posedge clk); #1;
      set_a(0, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
      if_main.b_req = 1'b0;
      checks++; if (if_main.b_rvalid !== 1'b1 || if_main.b_rdata !== 32'h77) begin failures++; $display("[TB] FAIL coll_old got rv=%b data=%h want 1 00000077", if_main.b_rvalid, if_main.b_rdata); end
      checks++; if (if_main.a_rvalid !== 1'b1 || if_main.a_err !== 1'b0) begin failures++; $display("[TB] FAIL coll_store_resp got rv=%b err=%b want 1 0", if_main.a_rvalid, if_main.a_err); end
      b_access(32'h40, rd, rv);
      checks++; if (rd !== 32'h5) begin failures++; $display("[TB] FAIL coll_new got %h want 00000005", rd); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd; logic er, rv;
      int n;
      rst_clr_n = 1'b0;
      @(posedge clk); #1;
      rst_clr_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      checks++; if (if_clr.a_ready !== 1'b0) begin failures++; $display("[TB] FAIL mid_clear_ready got %b want 0", if_clr.a_ready); end
      rst_clr_n = 1'b0;
      @(posedge clk); #1;
      rst_clr_n = 1'b1;
      n = 0;
      while (n < 40) begin
         @(posedge clk); #1;
         n++;
         if (if_clr.a_ready) break;
      end
      checks++; if (n !== 16) begin failures++; $display("[TB] FAIL clear_restart got %0d cycles want 16", n); end
      set_a(0, 1'b1, 1'b0, 32'h100, 2'd2, 1'b0, 32'h0);
      rst_main_n = 1'b0;
      @(posedge clk); #1;
      checks++; if (if_main.a_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL inflight_rvalid got %b want 0", if_main.a_rvalid); end
      rst_main_n = 1'b1;
      set_a(0, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
      a_access(0, 1'b0, 32'h100, 2'd2, 1'b0, 32'h0, rd, er, rv);
      checks++; if (rv !== 1'b1 || rd !== 32'hDD223344) begin failures++; $display("[TB] FAIL mem_kept got rv=%b data=%h want 1 dd223344", rv, rd); end
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      test_reset();
      test_clear();
      test_aligned();
      test_misaligned();
      test_back_to_back();
      test_range();
      test_wrap();
      test_mode1();
      test_collision();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
